mem_access_arbiter: RTL and testbench

- Sequences and shares the single-port data memory between the MEM-stage load/store path and the debug unit (memory dump over UART).
- Takes store data already masked by the store filter (SB/SH/word), generates byte enables and lane replication, and stalls the pipeline while a load is in flight or the debug unit holds the memory.
- The memory is a synchronous RAM with 1-cycle read latency.

---
 rtl/mem_access_arbiter_if.sv | 44 ++++
 rtl/mem_access_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_access_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_arbiter_if.sv
// Bundles the pipeline, debug and memory-side signals of the data memory arbiter.
// slave = arbiter view; master = environment (pipeline, debug unit and RAM).
interface mem_access_arbiter_if #(
  parameter int BITS_SIZE      = 32,
  parameter int BITS_EXTENSION = 2,
  parameter int ADDR_SIZE      = 10
);
  logic                      i_pipe_req;
  logic                      i_pipe_we;
  logic [ADDR_SIZE-1:0]      i_pipe_addr;
  logic [BITS_EXTENSION-1:0] i_pipe_size;
  logic [BITS_SIZE-1:0]      i_pipe_wdata;
  logic [BITS_SIZE-1:0]      o_pipe_rdata;
  logic                      o_pipe_valid;
  logic                      o_stall;
  logic                      o_misaligned;
  logic                      i_dbg_req;
  logic [ADDR_SIZE-3:0]      i_dbg_addr;
  logic [BITS_SIZE-1:0]      o_dbg_rdata;
  logic                      o_dbg_valid;
  logic                      o_mem_en;
  logic [BITS_SIZE/8-1:0]    o_mem_we;
  logic [ADDR_SIZE-3:0]      o_mem_addr;
  logic [BITS_SIZE-1:0]      o_mem_wdata;
  logic [BITS_SIZE-1:0]      i_mem_rdata;

  modport slave (
    input  i_pipe_req, i_pipe_we, i_pipe_addr, i_pipe_size, i_pipe_wdata,
    output o_pipe_rdata, o_pipe_valid, o_stall, o_misaligned,
    input  i_dbg_req, i_dbg_addr,
    output o_dbg_rdata, o_dbg_valid,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata
  );

  modport master (
    output i_pipe_req, i_pipe_we, i_pipe_addr, i_pipe_size, i_pipe_wdata,
    input  o_pipe_rdata, o_pipe_valid, o_stall, o_misaligned,
    output i_dbg_req, i_dbg_addr,
    input  o_dbg_rdata, o_dbg_valid,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Shares a 1-cycle-latency single-port data RAM between MEM-stage loads/stores
// and debug reads, with starvation-bounded debug priority.
module mem_access_arbiter #(
  parameter int BITS_SIZE      = 32,
  parameter int BITS_EXTENSION = 2,
  parameter int ADDR_SIZE      = 10,
  parameter int DBG_MAX_WAIT   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  mem_access_arbiter_if.slave  bus
);

  //  state     | meaning
  //  S_IDLE    | arbitrate, issue stores/loads/debug reads
  //  S_PIPE_RD | pipeline load data returning from RAM
  //  S_DBG_RD  | debug read data returning from RAM
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PIPE_RD = 2'd1;
  localparam logic [1:0] S_DBG_RD  = 2'd2;

  localparam logic [BITS_EXTENSION-1:0] SZ_WORD = BITS_EXTENSION'(0);
  localparam logic [BITS_EXTENSION-1:0] SZ_BYTE = BITS_EXTENSION'(1);
  localparam logic [BITS_EXTENSION-1:0] SZ_HALF = BITS_EXTENSION'(2);

  localparam int NB = BITS_SIZE / 8;
  localparam int CW = $clog2(DBG_MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(DBG_MAX_WAIT);

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        wait_cnt_q, wait_cnt_d;
  logic                 dbg_grant;
  logic                 misaligned;
  logic [NB-1:0]        store_we;
  logic [BITS_SIZE-1:0] store_data;

  always_comb begin
    misaligned = 1'b0;
    store_we   = '0;
    store_data = '0;
    case (bus.i_pipe_size)
      SZ_WORD: begin
        misaligned = (bus.i_pipe_addr[1:0] != 2'b00);
        store_we   = '1;
        store_data = bus.i_pipe_wdata;
      end
      SZ_BYTE: begin
        store_we   = {{(NB-1){1'b0}}, 1'b1} << bus.i_pipe_addr[1:0];
        store_data = {NB{bus.i_pipe_wdata[7:0]}};
      end
      SZ_HALF: begin
        misaligned = bus.i_pipe_addr[0];
        store_we   = {{(NB-2){1'b0}}, 2'b11} << bus.i_pipe_addr[1:0];
        store_data = {(NB/2){bus.i_pipe_wdata[15:0]}};
      end
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    dbg_grant        = 1'b0;
    bus.o_mem_en     = 1'b0;
    bus.o_mem_we     = '0;
    bus.o_mem_addr   = '0;
    bus.o_mem_wdata  = '0;
    bus.o_stall      = 1'b0;
    bus.o_misaligned = 1'b0;
    bus.o_pipe_valid = 1'b0;
    bus.o_pipe_rdata = '0;
    bus.o_dbg_valid  = 1'b0;
    bus.o_dbg_rdata  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_dbg_req && (!bus.i_pipe_req || wait_cnt_q == WAIT_MAX)) begin
          dbg_grant      = 1'b1;
          bus.o_mem_en   = 1'b1;
          bus.o_mem_addr = bus.i_dbg_addr;
          bus.o_stall    = bus.i_pipe_req;
          state_d        = S_DBG_RD;
        end else if (bus.i_pipe_req) begin
          if (misaligned) begin
            bus.o_misaligned = 1'b1;
          end else begin
            bus.o_mem_en   = 1'b1;
            bus.o_mem_addr = bus.i_pipe_addr[ADDR_SIZE-1:2];
            if (bus.i_pipe_we) begin
              bus.o_mem_we    = store_we;
              bus.o_mem_wdata = store_data;
            end else begin
              bus.o_stall = 1'b1;
              state_d     = S_PIPE_RD;
            end
          end
        end
      end
      // Held load request is not reissued here; it completes with this data.
      S_PIPE_RD: begin
        bus.o_pipe_valid = 1'b1;
        bus.o_pipe_rdata = bus.i_mem_rdata;
        state_d          = S_IDLE;
      end
      S_DBG_RD: begin
        bus.o_dbg_valid = 1'b1;
        bus.o_dbg_rdata = bus.i_mem_rdata;
        bus.o_stall     = bus.i_pipe_req;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_reset) begin
      bus.o_mem_en     = 1'b0;
      bus.o_mem_we     = '0;
      bus.o_mem_addr   = '0;
      bus.o_mem_wdata  = '0;
      bus.o_stall      = 1'b0;
      bus.o_misaligned = 1'b0;
      bus.o_pipe_valid = 1'b0;
      bus.o_pipe_rdata = '0;
      bus.o_dbg_valid  = 1'b0;
      bus.o_dbg_rdata  = '0;
    end
  end

  always_comb begin
    if (!bus.i_dbg_req || dbg_grant) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a byte-enable RAM model.
module tb_mem_access_arbiter;
  localparam int BS = 32;
  localparam int BE = 2;
  localparam int AS = 10;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   grant;

  always #5 clk = ~clk;

  mem_access_arbiter_if #(.BITS_SIZE(BS), .BITS_EXTENSION(BE), .ADDR_SIZE(AS)) bus ();

  mem_access_arbiter #(.BITS_SIZE(BS), .BITS_EXTENSION(BE), .ADDR_SIZE(AS), .DBG_MAX_WAIT(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  logic [31:0] mem_model [0:255];
  logic [31:0] mem_rdata;
  assign bus.i_mem_rdata = mem_rdata;

  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      mem_rdata <= mem_model[bus.o_mem_addr];
      for (int b = 0; b < 4; b++)
        if (bus.o_mem_we[b]) mem_model[bus.o_mem_addr][8*b +: 8] = bus.o_mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.i_pipe_req   = 1'b0;
    bus.i_pipe_we    = 1'b0;
    bus.i_pipe_addr  = '0;
    bus.i_pipe_size  = 2'b00;
    bus.i_pipe_wdata = '0;
    bus.i_dbg_req    = 1'b0;
    bus.i_dbg_addr   = '0;
  endtask

  task automatic set_pipe(input logic we, input logic [9:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata);
    bus.i_pipe_req   = 1'b1;
    bus.i_pipe_we    = we;
    bus.i_pipe_addr  = addr;
    bus.i_pipe_size  = size;
    bus.i_pipe_wdata = wdata;
  endtask

  task automatic do_store(input string tag, input logic [9:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata, input logic [3:0] exp_we,
                          input logic [31:0] exp_wdata);
    @(negedge clk);
    idle_in();
    set_pipe(1'b1, addr, size, wdata);
    #1;
    chk({tag, "_en"}, bus.o_mem_en, 1);
    chk({tag, "_we"}, bus.o_mem_we, exp_we);
    chk({tag, "_addr"}, bus.o_mem_addr, addr[9:2]);
    chk({tag, "_wdata"}, bus.o_mem_wdata, exp_wdata);
    chk({tag, "_stall"}, bus.o_stall, 0);
  endtask

  task automatic do_load(input string tag, input logic [9:0] addr, input logic [31:0] exp);
    @(negedge clk);
    idle_in();
    set_pipe(1'b0, addr, 2'b00, 32'h0);
    #1;
    chk({tag, "_issue_stall"}, bus.o_stall, 1);
    chk({tag, "_issue_en"}, bus.o_mem_en, 1);
    chk({tag, "_issue_we"}, bus.o_mem_we, 0);
    chk({tag, "_issue_addr"}, bus.o_mem_addr, addr[9:2]);
    chk({tag, "_issue_valid"}, bus.o_pipe_valid, 0);
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, bus.o_pipe_valid, 1);
    chk({tag, "_rdata"}, bus.o_pipe_rdata, exp);
    chk({tag, "_rd_stall"}, bus.o_stall, 0);
    chk({tag, "_rd_noreissue"}, bus.o_mem_en, 0);
  endtask

  task automatic do_misaligned(input string tag, input logic we, input logic [9:0] addr,
                               input logic [1:0] size);
    @(negedge clk);
    idle_in();
    set_pipe(we, addr, size, 32'h1111_1111);
    #1;
    chk({tag, "_mis"}, bus.o_misaligned, 1);
    chk({tag, "_en"}, bus.o_mem_en, 0);
    chk({tag, "_stall"}, bus.o_stall, 0);
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    set_pipe(1'b0, 10'h020, 2'b00, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_en", bus.o_mem_en, 0);
    chk("rst_stall", bus.o_stall, 0);
    chk("rst_valid", bus.o_pipe_valid, 0);
    chk("rst_dvalid", bus.o_dbg_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_in();

    do_store("st_word", 10'h010, 2'b00, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    do_store("st_byte", 10'h013, 2'b01, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
    do_store("st_half", 10'h012, 2'b10, 32'h00001234, 4'b1100, 32'h12341234);
    do_store("st_byte0", 10'h011, 2'b01, 32'h00000077, 4'b0010, 32'h77777777);
    do_store("st_w20", 10'h020, 2'b00, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
    do_store("st_w14", 10'h014, 2'b00, 32'h55AA1234, 4'b1111, 32'h55AA1234);

    do_load("ld_20", 10'h020, 32'hCAFEF00D);
    do_store("st_after_rd", 10'h018, 2'b10, 32'h0000BEEF, 4'b0011, 32'hBEEFBEEF);
    @(negedge clk);
    idle_in();
    #1;
    chk("idle_valid", bus.o_pipe_valid, 0);
    chk("idle_rdata", bus.o_pipe_rdata, 0);
    // 0x010: DEADBEEF, byte3<=A5, half1<=1234, byte1<=77
    do_load("ld_10", 10'h010, 32'h1234_77EF);

    do_misaligned("mis_half", 1'b0, 10'h021, 2'b10);
    do_misaligned("mis_size3", 1'b0, 10'h020, 2'b11);
    do_misaligned("mis_word", 1'b1, 10'h022, 2'b00);
    @(negedge clk);
    idle_in();
    #1;
    chk("mis_clear", bus.o_misaligned, 0);

    @(negedge clk);
    idle_in();
    bus.i_dbg_req  = 1'b1;
    bus.i_dbg_addr = 8'h05;
    #1;
    chk("dbg_solo_en", bus.o_mem_en, 1);
    chk("dbg_solo_addr", bus.o_mem_addr, 8'h05);
    chk("dbg_solo_stall", bus.o_stall, 0);
    @(negedge clk);
    #1;
    chk("dbg_solo_valid", bus.o_dbg_valid, 1);
    chk("dbg_solo_rdata", bus.o_dbg_rdata, 32'h55AA1234);
    @(negedge clk);
    idle_in();
    #1;
    chk("dbg_idle_valid", bus.o_dbg_valid, 0);
    chk("dbg_idle_rdata", bus.o_dbg_rdata, 0);

    @(negedge clk);
    set_pipe(1'b0, 10'h020, 2'b00, 32'h0);
    bus.i_dbg_req  = 1'b1;
    bus.i_dbg_addr = 8'h05;
    grant = -1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.o_mem_en && bus.o_mem_addr == 8'h05) begin
        grant = c;
        break;
      end
      @(negedge clk);
    end
    chk("dbg_grant_cycle", grant, 4);
    chk("dbg_issue_stall", bus.o_stall, 1);
    @(negedge clk);
    #1;
    chk("dbg_valid", bus.o_dbg_valid, 1);
    chk("dbg_rdata", bus.o_dbg_rdata, 32'h55AA1234);
    chk("dbg_rd_stall", bus.o_stall, 1);
    chk("dbg_rd_pvalid", bus.o_pipe_valid, 0);
    @(negedge clk);
    bus.i_dbg_req = 1'b0;
    #1;
    chk("post_dbg_issue", bus.o_mem_addr, 8'h08);
    chk("post_dbg_stall", bus.o_stall, 1);
    @(negedge clk);
    #1;
    chk("post_dbg_valid", bus.o_pipe_valid, 1);
    chk("post_dbg_rdata", bus.o_pipe_rdata, 32'hCAFEF00D);

    @(negedge clk);
    idle_in();
    set_pipe(1'b0, 10'h020, 2'b00, 32'h0);
    #1;
    chk("rstrd_issue_stall", bus.o_stall, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstrd_valid", bus.o_pipe_valid, 0);
    chk("rstrd_rdata", bus.o_pipe_rdata, 0);
    chk("rstrd_stall", bus.o_stall, 0);
    chk("rstrd_en", bus.o_mem_en, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstrd_novalid", bus.o_pipe_valid, 0);
    chk("rstrd_reissue_stall", bus.o_stall, 1);
    chk("rstrd_reissue_en", bus.o_mem_en, 1);
    @(negedge clk);
    #1;
    chk("rstrd_valid2", bus.o_pipe_valid, 1);
    chk("rstrd_rdata2", bus.o_pipe_rdata, 32'hCAFEF00D);
    @(negedge clk);
    idle_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
